rotate_rows: RTL and testbench

Registered AES ShiftRows stage for the AES-128 datapath control. Takes a 128-bit AES state, cyclically left-rotates each of the four state rows by its row index, and presents the result one clock later with a valid flag. It sits between SubBytes and MixColumns in the round pipeline. The state is held column-major, with byte 0 in the MSBs.

---
 rtl/aes_pkg.sv | 16 +
 rtl/rotate_row.sv | 33 +++
 rtl/rotate_rows.sv | 60 ++++++
 tb/tb_rotate_rows.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 datapath definitions: state geometry, byte/state types and
// the column-major byte index helper.
package aes_pkg;

    localparam int unsigned AES_NB    = 4;
    localparam int unsigned AES_BYTES = 16;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [127:0] aes_state_t;

    // Byte position of state element (row r, column c); byte 0 sits in the MSBs.
    function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
        return AES_NB * c + r;
    endfunction

endpackage

// File: rtl/rotate_row.sv
// Cyclic left rotation of one 4-byte AES state row.
// Ports:
//   row_in  : bytes of the row, column 0 in the MSBs
//   amt     : rotate amount 0..3
//   inv     : 1 = rotate right instead (only with ROTATE_INV_EN)
//   row_out : rotated row, column 0 in the MSBs
// Configuration macro: ROTATE_INV_EN adds the inv port and the inverse direction.
module rotate_row
    import aes_pkg::*;
(
    input  logic [31:0] row_in,
    input  logic [1:0]  amt,
`ifdef ROTATE_INV_EN
    input  logic        inv,
`endif
    output logic [31:0] row_out
);

    aes_byte_t  b_in [AES_NB];
    logic [1:0] sel  [AES_NB];

    for (genvar c = 0; c < AES_NB; c++) begin : g_col
        assign b_in[c] = row_in[31-8*c -: 8];
        // Source column wraps modulo 4 through the 2-bit arithmetic.
`ifdef ROTATE_INV_EN
        assign sel[c] = inv ? (2'(c) - amt) : (2'(c) + amt);
`else
        assign sel[c] = 2'(c) + amt;
`endif
        assign row_out[31-8*c -: 8] = b_in[sel[c]];
    end

endmodule

// File: rtl/rotate_rows.sv
// Registered AES ShiftRows stage: rotates state row r left by r bytes and
// presents the result one cycle later with a valid flag.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : in carries a state this cycle
//   in        : input state (column-major, byte 0 in MSBs)
//   inv       : select inverse rotation (only with ROTATE_INV_EN)
//   out_valid : out holds a transformed state
//   out       : rotated state, registered; holds when in_valid is low
// Configuration macro: ROTATE_INV_EN.
module rotate_rows
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  aes_state_t in,
`ifdef ROTATE_INV_EN
    input  logic       inv,
`endif
    output logic       out_valid,
    output aes_state_t out
);

    aes_state_t perm_c;

    // Gather each row, rotate it by its row index, scatter it back.
    for (genvar r = 0; r < AES_NB; r++) begin : g_row
        logic [31:0] row_in;
        logic [31:0] row_out;

        for (genvar c = 0; c < AES_NB; c++) begin : g_col
            assign row_in[31-8*c -: 8]                    = in[127-8*byte_idx(r, c) -: 8];
            assign perm_c[127-8*byte_idx(r, c) -: 8]      = row_out[31-8*c -: 8];
        end

        rotate_row u_rotate_row (
            .row_in  (row_in),
            .amt     (2'(r)),
`ifdef ROTATE_INV_EN
            .inv     (inv),
`endif
            .row_out (row_out)
        );
    end

    // Output and valid registers; data holds while no valid input arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= perm_c;
            end
        end
    end

endmodule

// File: tb/tb_rotate_rows.sv
// Self-checking bench for rotate_rows: directed vectors, reset, hold,
// back-to-back streaming and (with ROTATE_INV_EN) inverse/round trip.
module tb_rotate_rows;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in;
`ifdef ROTATE_INV_EN
    logic         inv;
`endif
    logic         out_valid;
    logic [127:0] out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rotate_rows dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in),
`ifdef ROTATE_INV_EN
        .inv       (inv),
`endif
        .out_valid (out_valid),
        .out       (out)
    );

    // Reference: out(r,c) = in(r,(c+r) mod 4), or (c-r) mod 4 for the inverse.
    function automatic logic [127:0] ref_rot(input logic [127:0] s, input bit inverse);
        logic [127:0] o;
        int r, c, src;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            r   = k % 4;
            c   = k / 4;
            src = inverse ? (c + 4 - r) % 4 : (c + r) % 4;
            o[127-8*k -: 8] = s[127-8*(4*src + r) -: 8];
        end
        return o;
    endfunction

    // Advance past one rising edge; inputs and samples are placed 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in = 128'h0123456789ABCDEF0123456789ABCDEF;
        step();
        in = 128'hFFEEDDCCBBAA99887766554433221100;
        step();
        total++; if (out !== 128'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", out, 128'h0); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        rst = 1'b0;
        in  = 128'h0123456789ABCDEF0123456789ABCDEF;
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL post_reset_valid got=%b exp=1", out_valid); end
        total++; if (out !== 128'h01AB45EF8923CD6701AB45EF8923CD67) begin bad++;
            $display("FAIL post_reset_out got=%h exp=%h", out, 128'h01AB45EF8923CD6701AB45EF8923CD67); end
    endtask

    task automatic test_forward();
        in_valid = 1'b1; in = 128'hd42711aee0bf98f1b8b45de51e415230;
        step();
        total++; if (out !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin bad++;
            $display("FAIL fips_out got=%h exp=%h", out, 128'hd4bf5d30e0b452aeb84111f11e2798e5); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fips_valid got=%b exp=1", out_valid); end
        // Row 0 only: must pass through untouched.
        in = 128'hAA000000BB000000CC000000DD000000;
        step();
        total++; if (out !== 128'hAA000000BB000000CC000000DD000000) begin bad++;
            $display("FAIL row0_out got=%h exp=%h", out, 128'hAA000000BB000000CC000000DD000000); end
        // Row 3 only: 11,22,33,44 in columns 0..3 become 44,11,22,33.
        in = 128'h00000011000000220000003300000044;
        step();
        total++; if (out !== 128'h00000044000000110000002200000033) begin bad++;
            $display("FAIL row3_out got=%h exp=%h", out, 128'h00000044000000110000002200000033); end
    endtask

    task automatic test_hold();
        logic [127:0] held;
        held = out;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in = {4{$urandom}};
            step();
            total++; if (out !== held) begin bad++; $display("FAIL hold_out cyc=%0d got=%h exp=%h", i, out, held); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] st;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            in = st;
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid idx=%0d got=%b exp=1", i, out_valid); end
            total++; if (out !== ref_rot(st, 1'b0)) begin bad++;
                $display("FAIL b2b_out idx=%0d got=%h exp=%h", i, out, ref_rot(st, 1'b0)); end
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_midstream_reset();
        in_valid = 1'b1; in = 128'hd42711aee0bf98f1b8b45de51e415230;
        rst = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || out !== 128'h0) begin bad++;
            $display("FAIL mid_reset got=%b/%h exp=0/0", out_valid, out); end
        rst = 1'b0;
        step();
        total++; if (out !== 128'hd4bf5d30e0b452aeb84111f11e2798e5 || out_valid !== 1'b1) begin bad++;
            $display("FAIL mid_reset_resume got=%b/%h exp=1/%h", out_valid, out, 128'hd4bf5d30e0b452aeb84111f11e2798e5); end
    endtask

`ifdef ROTATE_INV_EN
    task automatic test_inverse();
        logic [127:0] st;
        logic [127:0] fwd;
        in_valid = 1'b1; inv = 1'b1; in = 128'h01AB45EF8923CD6701AB45EF8923CD67;
        step();
        total++; if (out !== 128'h0123456789ABCDEF0123456789ABCDEF) begin bad++;
            $display("FAIL inv_vec got=%h exp=%h", out, 128'h0123456789ABCDEF0123456789ABCDEF); end
        for (int i = 0; i < 6; i++) begin
            st  = {$urandom, $urandom, $urandom, $urandom};
            inv = i[0];
            in  = st;
            step();
            total++; if (out !== ref_rot(st, i[0])) begin bad++;
                $display("FAIL inv_alt idx=%0d got=%h exp=%h", i, out, ref_rot(st, i[0])); end
        end
        for (int i = 0; i < 3; i++) begin
            st  = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'b0; in = st;
            step();
            fwd = out;
            inv = 1'b1; in = fwd;
            step();
            total++; if (out !== st) begin bad++; $display("FAIL round_trip idx=%0d got=%h exp=%h", i, out, st); end
        end
        inv = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in = '0;
`ifdef ROTATE_INV_EN
        inv = 1'b0;
`endif
        #1;
        test_reset();
        test_forward();
        test_hold();
        test_back_to_back();
        test_midstream_reset();
`ifdef ROTATE_INV_EN
        test_inverse();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
